dac_spi_tx: RTL and testbench
=============================

DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 Parameter CLK_DIV, default 2, clk cycles per SCLK half-period; legal range 1..255.
REQ-002 Parameter CFG_BITS, default 4'b0011, 4-bit DAC command header prepended to every frame.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 sample_valid  input  1  upstream sample (sine generator output) is present.
REQ-006 sample_data  input  12  unsigned offset-binary sample; transmitted unmodified.
REQ-007 sample_ready  output  1  block accepts sample this cycle.
REQ-008 sclk  output  1  SPI clock, idle low.
REQ-009 mosi  output  1  SPI data, MSB first.
REQ-010 cs_n  output  1  DAC chip select, active low.
REQ-011 ldac_n  output  1  DAC latch strobe, active low.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 frame_done  output  1  one-cycle pulse at end of each frame.

Function
REQ-014 The block SHALL contain FSM states IDLE, SETUP, SHIFT, CS_HI, LDAC.
REQ-015 A transfer SHALL occur on a rising edge where sample_valid and sample_ready are both high; the block SHALL latch {CFG_BITS, sample_data} into a 16-bit shift register and enter SETUP.
REQ-016 In IDLE: cs_n=1, sclk=0, ldac_n=1, mosi=0, busy=0, sample_ready=1.
REQ-017 SETUP SHALL last CLK_DIV cycles with cs_n=0, sclk=0, mosi=frame bit 15.
REQ-018 SHIFT SHALL emit 16 bits; each bit is CLK_DIV cycles sclk=1 followed by CLK_DIV cycles sclk=0.
REQ-019 mosi SHALL change only in the first cycle of an sclk-low phase and hold stable while sclk=1.
REQ-020 After the low phase of bit 0, CS_HI SHALL last CLK_DIV cycles with cs_n=1, sclk=0.
REQ-021 LDAC SHALL last CLK_DIV cycles with ldac_n=0; frame_done SHALL be 1 in its final cycle only; the next state is IDLE.
REQ-022 Accept to next sample_ready=1 SHALL be exactly 35*CLK_DIV+1 cycles (71 at CLK_DIV=2) with no buffer.
REQ-023 Bit and divider counters SHALL saturate-free wrap only at frame boundaries; a new frame SHALL always begin from bit 15.
REQ-024 sample_valid held high continuously SHALL yield back-to-back frames with no lost or duplicated sample.
REQ-025 sample_data changes while busy SHALL not affect the frame in flight.

Reset
REQ-026 reset SHALL force IDLE on the next edge regardless of state: cs_n=1, ldac_n=1, sclk=0, mosi=0, busy=0, frame_done=0, sample_ready=1 (0 if buffer enabled and full is impossible after reset: buffer cleared).
REQ-027 Reset mid-frame SHALL abort the frame with no ldac_n pulse; reset has priority over a simultaneous handshake.

Configuration
REQ-028 Macro DAC_SPI_SKID_EN SHALL, when defined, add a one-entry sample buffer.
REQ-029 With DAC_SPI_SKID_EN: sample_ready = buffer empty (also high while busy); a buffered sample SHALL start SETUP on the cycle after frame_done, skipping IDLE; a handshake in the frame_done cycle goes straight to SETUP.
REQ-030 Without DAC_SPI_SKID_EN: sample_ready = (state==IDLE) and no buffer logic exists.

Verification
REQ-031 CLK_DIV=2, send 12'hABC -> mosi captured on sclk rising edges = 16'h3ABC, 16 rising edges, cs_n low 66 cycles, ldac_n low 2 cycles, one frame_done.
REQ-032 CLK_DIV=1, valid held high with samples 12'h000,12'hFFF,12'h800 -> three frames 16'h3000,16'h3FFF,16'h3800 in order, sample_ready interval 36 cycles (no buffer).
REQ-033 Assert reset at bit 7 of a frame -> next cycle cs_n=1, sclk=0, no ldac_n pulse, sample_ready=1.
REQ-034 Change sample_data every cycle during frame of 12'h555 -> transmitted word 16'h3555.
REQ-035 DAC_SPI_SKID_EN, CLK_DIV=2, second sample 12'h123 offered mid-frame -> accepted immediately, SETUP starts cycle after frame_done, frame 16'h3123.
REQ-036 CLK_DIV=3, idle with sample_valid=0 for 100 cycles -> cs_n, ldac_n stay 1, sclk 0, busy 0.

Source files
------------

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: SPI transmitter that sends 12-bit samples to a DAC as 16-bit frames.
// Optional one-entry sample buffer when DAC_SPI_SKID_EN is defined.
module dac_spi_tx #(
    parameter int unsigned CLK_DIV  = 2,
    parameter logic [3:0]  CFG_BITS = 4'b0011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] sample_data,
    output logic        sample_ready,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic        ldac_n,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        CS_HI,
        LDAC
    } state_e;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic        low_q, low_d;
    logic [15:0] shreg_q, shreg_d;

    logic        div_end;
    logic        accept;
    logic        start;
    logic [11:0] start_data;

    assign div_end = (div_q == DIV_LAST);
    assign accept  = sample_valid && sample_ready;

`ifdef DAC_SPI_SKID_EN
    logic        buf_valid_q, buf_valid_d;
    logic [11:0] buf_data_q, buf_data_d;

    assign sample_ready = !buf_valid_q;
`else
    assign sample_ready = (state_q == IDLE);
`endif

    // Next-state logic: phase timing, bit sequencing and frame launch
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        low_d      = low_q;
        shreg_d    = shreg_q;
        frame_done = 1'b0;
        start      = 1'b0;
        start_data = sample_data;
`ifdef DAC_SPI_SKID_EN
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
`endif
        unique case (state_q)
            IDLE: begin
                start = accept;
            end
            SETUP: begin
                if (div_end) begin
                    state_d = SHIFT;
                    div_d   = 8'd0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (!div_end) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = 8'd0;
                    if (!low_q) begin
                        // next bit appears at the start of the low phase
                        low_d   = 1'b1;
                        shreg_d = {shreg_q[14:0], 1'b0};
                    end else if (bit_q == 4'd0) begin
                        state_d = CS_HI;
                    end else begin
                        low_d = 1'b0;
                        bit_d = bit_q - 4'd1;
                    end
                end
            end
            CS_HI: begin
                if (div_end) begin
                    state_d = LDAC;
                    div_d   = 8'd0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            LDAC: begin
                if (!div_end) begin
                    div_d = div_q + 8'd1;
                end else begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                    div_d      = 8'd0;
`ifdef DAC_SPI_SKID_EN
                    if (buf_valid_q) begin
                        start       = 1'b1;
                        start_data  = buf_data_q;
                        buf_valid_d = 1'b0;
                    end else begin
                        start = accept;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef DAC_SPI_SKID_EN
        // park a sample offered mid-frame until the current one finishes
        if (accept && state_q != IDLE && !(state_q == LDAC && div_end)) begin
            buf_valid_d = 1'b1;
            buf_data_d  = sample_data;
        end
`endif

        if (start) begin
            state_d = SETUP;
            div_d   = 8'd0;
            bit_d   = 4'd15;
            low_d   = 1'b0;
            shreg_d = {CFG_BITS, start_data};
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= 8'd0;
            bit_q   <= 4'd15;
            low_q   <= 1'b0;
            shreg_q <= 16'd0;
`ifdef DAC_SPI_SKID_EN
            buf_valid_q <= 1'b0;
            buf_data_q  <= 12'd0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            low_q   <= low_d;
            shreg_q <= shreg_d;
`ifdef DAC_SPI_SKID_EN
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
`endif
        end
    end

    assign busy   = (state_q != IDLE);
    assign sclk   = (state_q == SHIFT) && !low_q;
    assign mosi   = busy && shreg_q[15];
    assign cs_n   = !(state_q == SETUP || state_q == SHIFT);
    assign ldac_n = (state_q != LDAC);

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: checks dac_spi_tx at CLK_DIV 1, 2 and 3 against a
// frame-timeline reference model, a vector table and directed sequences.
module tb_dac_spi_tx;

    localparam int N = 3;
    localparam logic [3:0] CFG = 4'b0011;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld  [N];
    logic [11:0] dat  [N];
    logic        rdy  [N];
    logic        sclk [N];
    logic        mosi [N];
    logic        csn  [N];
    logic        ldn  [N];
    logic        bsy  [N];
    logic        fd   [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dac_spi_tx #(
            .CLK_DIV (g + 1),
            .CFG_BITS(CFG)
        ) u_dut (
            .clk         (clk),
            .reset       (rst),
            .sample_valid(vld[g]),
            .sample_data (dat[g]),
            .sample_ready(rdy[g]),
            .sclk        (sclk[g]),
            .mosi        (mosi[g]),
            .cs_n        (csn[g]),
            .ldac_n      (ldn[g]),
            .busy        (bsy[g]),
            .frame_done  (fd[g])
        );
    end

    // reference model: t = cycles since accept (0 = idle), cur = word in flight
    int          t     [N];
    logic [15:0] cur   [N];
    logic        bv    [N];
    logic [15:0] bw    [N];
    logic [15:0] capw  [N];
    int          edges [N];
    int          cslow [N];
    int          ldlow [N];
    int          frames[N];
    logic [15:0] hist  [N][64];
    logic        psclk [N];
    logic        pmosi [N];
    int          cyc;
    int          checks;
    int          errors;

    typedef struct {
        int          inst;
        logic [11:0] s;
        logic [15:0] w;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc%0d got %h want %h",
                     nm, i, cyc, act, exp);
        end
    endtask

    task automatic clear_cap(input int i);
        capw[i]  = 16'd0;
        edges[i] = 0;
        cslow[i] = 0;
        ldlow[i] = 0;
    endtask

    function automatic logic model_ready(input int i);
`ifdef DAC_SPI_SKID_EN
        return !bv[i];
`else
        return t[i] == 0;
`endif
    endfunction

    task automatic model_update();
        for (int i = 0; i < N; i++) begin
            int   flen = 35 * (i + 1);
            logic acc  = vld[i] && model_ready(i);
            if (rst) begin
                t[i]  = 0;
                bv[i] = 1'b0;
                clear_cap(i);
            end else if (t[i] == 0) begin
                if (acc) begin
                    t[i]   = 1;
                    cur[i] = {CFG, dat[i]};
                end
            end else if (t[i] == flen) begin
`ifdef DAC_SPI_SKID_EN
                if (bv[i]) begin
                    t[i]   = 1;
                    cur[i] = bw[i];
                    bv[i]  = 1'b0;
                end else if (acc) begin
                    t[i]   = 1;
                    cur[i] = {CFG, dat[i]};
                end else begin
                    t[i] = 0;
                end
`else
                t[i] = 0;
`endif
            end else begin
`ifdef DAC_SPI_SKID_EN
                if (acc) begin
                    bv[i] = 1'b1;
                    bw[i] = {CFG, dat[i]};
                end
`endif
                t[i]++;
            end
        end
    endtask

    task automatic compare_cycle();
        for (int i = 0; i < N; i++) begin
            int       d    = i + 1;
            int       u    = t[i] - 1;
            int       s    = 0;
            int       b    = 0;
            logic     hi   = 1'b0;
            logic     mchk = 1'b0;
            logic     em   = 1'b0;
            logic     insh = 1'b0;
            logic     erdy = model_ready(i);
            logic [5:0] e;
            if (t[i] == 0) begin
                e    = {erdy, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
                mchk = 1'b1;
            end else if (u < d) begin
                e    = {erdy, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
                mchk = 1'b1;
                em   = cur[i][15];
            end else if (u < 33 * d) begin
                s    = u - d;
                b    = 15 - s / (2 * d);
                hi   = (s % (2 * d)) < d;
                insh = 1'b1;
                e    = {erdy, 1'b1, 1'b0, hi, 1'b1, 1'b0};
                if (hi) begin
                    mchk = 1'b1;
                    em   = cur[i][b];
                end
            end else if (u < 34 * d) begin
                e = {erdy, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
            end else begin
                e = {erdy, 1'b1, 1'b1, 1'b0, 1'b0, (u == 35 * d - 1)};
            end
            chk("ctl{rdy,busy,cs_n,sclk,ldac_n,done}", i,
                {26'd0, rdy[i], bsy[i], csn[i], sclk[i], ldn[i], fd[i]},
                {26'd0, e});
            if (mchk) chk("mosi", i, {31'd0, mosi[i]}, {31'd0, em});
            if (insh)
                chk("mosi_hold", i,
                    {31'd0, (mosi[i] != pmosi[i]) && (s % (2 * d) != d)},
                    32'd0);
            if (sclk[i] && !psclk[i]) begin
                capw[i] = {capw[i][14:0], mosi[i]};
                edges[i]++;
            end
            if (!csn[i]) cslow[i]++;
            if (!ldn[i]) ldlow[i]++;
            if (fd[i]) begin
                chk("frame_word", i, {16'd0, capw[i]}, {16'd0, cur[i]});
                chk("sclk_edges", i, edges[i], 16);
                chk("cs_low_cycles", i, cslow[i], 33 * d);
                chk("ldac_low_cycles", i, ldlow[i], d);
                hist[i][frames[i] % 64] = capw[i];
                frames[i]++;
                clear_cap(i);
            end
            psclk[i] = sclk[i];
            pmosi[i] = mosi[i];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        compare_cycle();
    endtask

    task automatic send(input int i, input logic [11:0] s);
        int c = 0;
        while (!(t[i] == 0 && !bv[i]) && c < 400) begin
            cycle();
            c++;
        end
        vld[i] = 1'b1;
        dat[i] = s;
        cycle();
        vld[i] = 1'b0;
        chk("accept", i, t[i], 1);
    endtask

    task automatic wait_frames(input int i, input int target,
                               input int budget, input logic scramble);
        int c = 0;
        while (frames[i] < target && c < budget) begin
            if (scramble) dat[i] = 12'($urandom_range(0, 4095));
            cycle();
            c++;
        end
        chk("frame_timeout", i, {31'd0, frames[i] >= target}, 32'd1);
    endtask

    initial begin
        logic [11:0] smp [3];
        int          at  [3];
        int          k;
        int          f0;
        int          bad;
        logic        r;

        checks = 0;
        errors = 0;
        cyc    = 0;
        for (int i = 0; i < N; i++) begin
            vld[i]    = 1'b0;
            dat[i]    = 12'd0;
            t[i]      = 0;
            cur[i]    = 16'd0;
            bv[i]     = 1'b0;
            bw[i]     = 16'd0;
            frames[i] = 0;
            psclk[i]  = 1'b0;
            pmosi[i]  = 1'b0;
            clear_cap(i);
        end

        tv[0] = '{1, 12'hABC, 16'h3ABC};
        tv[1] = '{1, 12'h555, 16'h3555};
        tv[2] = '{0, 12'h000, 16'h3000};
        tv[3] = '{0, 12'hFFF, 16'h3FFF};
        tv[4] = '{2, 12'h800, 16'h3800};
        tv[5] = '{2, 12'h7E1, 16'h37E1};

        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        for (int i = 0; i < N; i++)
            chk("reset_idle", i,
                {28'd0, rdy[i], bsy[i], csn[i], ldn[i]}, 32'b1011);

        // vector table: one frame each, sample_data scrambled while in flight
        for (int v = 0; v < 6; v++) begin
            int i = tv[v].inst;
            f0 = frames[i];
            send(i, tv[v].s);
            wait_frames(i, f0 + 1, 40 * (i + 1) + 10, 1'b1);
            chk("vec_word", i, {16'd0, hist[i][f0 % 64]}, {16'd0, tv[v].w});
        end

        // valid held high, three samples back to back at CLK_DIV=1
        smp[0] = 12'h000;
        smp[1] = 12'hFFF;
        smp[2] = 12'h800;
        f0 = frames[0];
        k = 0;
        vld[0] = 1'b1;
        dat[0] = smp[0];
        for (int c = 0; c < 200 && k < 3; c++) begin
            r = rdy[0];
            cycle();
            if (r) begin
                at[k] = cyc;
                k++;
                if (k < 3) dat[0] = smp[k];
            end
        end
        vld[0] = 1'b0;
        chk("b2b_accepts", 0, k, 3);
`ifndef DAC_SPI_SKID_EN
        if (k == 3) begin
            chk("b2b_interval1", 0, at[1] - at[0], 36);
            chk("b2b_interval2", 0, at[2] - at[1], 36);
        end
`endif
        wait_frames(0, f0 + 3, 150, 1'b0);
        chk("b2b_w0", 0, {16'd0, hist[0][f0 % 64]}, 32'h3000);
        chk("b2b_w1", 0, {16'd0, hist[0][(f0 + 1) % 64]}, 32'h3FFF);
        chk("b2b_w2", 0, {16'd0, hist[0][(f0 + 2) % 64]}, 32'h3800);

        // reset during bit 7 of a CLK_DIV=2 frame
        send(1, 12'h2A5);
        k = 0;
        while (t[1] != 35 && k < 100) begin
            cycle();
            k++;
        end
        chk("reached_bit7", 1, t[1], 35);
        f0 = frames[1];
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("abort_idle", 1,
            {28'd0, csn[1], sclk[1], rdy[1], bsy[1]}, 32'b1010);
        bad = 0;
        repeat (80) begin
            cycle();
            if (!ldn[1]) bad++;
        end
        chk("abort_no_ldac", 1, bad, 0);
        chk("abort_no_frame", 1, frames[1], f0);

        // reset wins over a simultaneous handshake
        vld[0] = 1'b1;
        dat[0] = 12'h321;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        vld[0] = 1'b0;
        chk("reset_prio", 0, {30'd0, bsy[0], rdy[0]}, 32'b01);

        // CLK_DIV=3 left idle
        bad = 0;
        repeat (100) begin
            cycle();
            if (csn[2] !== 1'b1 || ldn[2] !== 1'b1 ||
                sclk[2] !== 1'b0 || bsy[2] !== 1'b0) bad++;
        end
        chk("idle_d3", 2, bad, 0);

`ifdef DAC_SPI_SKID_EN
        // second sample offered mid-frame is buffered and follows directly
        f0 = frames[1];
        send(1, 12'h111);
        repeat (20) cycle();
        vld[1] = 1'b1;
        dat[1] = 12'h123;
        r = rdy[1];
        cycle();
        vld[1] = 1'b0;
        chk("skid_ready_mid", 1, {31'd0, r}, 32'd1);
        chk("skid_full", 1, {31'd0, rdy[1]}, 32'd0);
        k = 0;
        while (!fd[1] && k < 100) begin
            cycle();
            k++;
        end
        chk("skid_done_seen", 1, {31'd0, fd[1]}, 32'd1);
        cycle();
        chk("skid_setup_next", 1, {30'd0, bsy[1], csn[1]}, 32'b10);
        wait_frames(1, f0 + 2, 100, 1'b0);
        chk("skid_word", 1, {16'd0, hist[1][(f0 + 1) % 64]}, 32'h3123);
`endif

        // randomized traffic with occasional reset
        repeat (2500) begin
            for (int i = 0; i < N; i++) begin
                vld[i] = ($urandom_range(0, 2) == 0);
                dat[i] = 12'($urandom_range(0, 4095));
            end
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;
        for (int i = 0; i < N; i++) vld[i] = 1'b0;
        repeat (250) cycle();
        for (int i = 0; i < N; i++)
            chk("drained_idle", i, {31'd0, bsy[i]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
